// File: rtl/mem_responder.sv
// Word-organised RAM behind a request/ready handshake with a configurable number of wait states.
// Illegal (misaligned or out-of-range) accesses complete normally but raise err and return zero.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] adr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic          capture;
  logic          access;
  logic          acc_we;
  logic [31:0]   acc_adr;
  logic [31:0]   acc_wdata;
  logic          acc_illegal;
  logic [AW-1:0] acc_idx;
  logic          mem_we;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero latency the access happens on the capture edge, so it must use the live inputs.
  assign acc_we    = (state_q == StIdle) ? we    : we_q;
  assign acc_adr   = (state_q == StIdle) ? adr   : adr_q;
  assign acc_wdata = (state_q == StIdle) ? wdata : wdata_q;

  assign acc_illegal = (acc_adr[1:0] != 2'b00) ||
                       ({2'b00, acc_adr[31:2]} >= 32'(DEPTH_WORDS));
  assign acc_idx     = acc_adr[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          capture = 1'b1;
          if (LATENCY == 0) begin
            access  = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d   = 4'(LATENCY);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Response registers: ready/err only live for the RESP cycle, rdata holds until the next read.
  always_comb begin
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    if (access) begin
      ready_d = 1'b1;
      err_d   = acc_illegal;
      if (acc_illegal) begin
        rdata_d = '0;
      end else if (!acc_we) begin
        rdata_d = mem[acc_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      we_q    <= we;
      adr_q   <= adr;
      wdata_q <= wdata;
    end
  end

  // Reset blocks the commit so an aborted or not-yet-started write never reaches the array.
  assign mem_we = access && acc_we && !acc_illegal && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (latency 0, 2, 5) with a scoreboard for the latency-2
// instance's read data and error flags.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req2, req5;
  logic        we;
  logic [31:0] adr, wdata;
  logic [31:0] rdata0, rdata2, rdata5;
  logic        ready0, ready2, ready5;
  logic        err0, err2, err5;
  logic        busy0, busy2, busy5;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .adr(adr), .wdata(wdata),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
  );

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .we(we), .adr(adr), .wdata(wdata),
    .rdata(rdata2), .ready(ready2), .err(err2), .busy(busy2)
  );

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(5)) dut5 (
    .clk(clk), .reset(reset), .req(req5), .we(we), .adr(adr), .wdata(wdata),
    .rdata(rdata5), .ready(ready5), .err(err5), .busy(busy5)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl_mem [64];
  logic [31:0] mdl_rdata;
  int          checks = 0;
  int          passed = 0;

  function automatic logic obs_ready(input int sel);
    return (sel == 0) ? ready0 : (sel == 5) ? ready5 : ready2;
  endfunction

  function automatic logic obs_busy(input int sel);
    return (sel == 0) ? busy0 : (sel == 5) ? busy5 : busy2;
  endfunction

  function automatic logic obs_err(input int sel);
    return (sel == 0) ? err0 : (sel == 5) ? err5 : err2;
  endfunction

  function automatic logic [31:0] obs_rdata(input int sel);
    return (sel == 0) ? rdata0 : (sel == 5) ? rdata5 : rdata2;
  endfunction

  // Reference behaviour of the latency-2 instance; result pushed when the request is driven.
  task automatic predict(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    if (a[1:0] != 2'b00 || a[31:2] >= 30'd64) begin
      mdl_rdata = '0;
      e.err     = 1'b1;
    end else begin
      e.err = 1'b0;
      if (w) mdl_mem[a[7:2]] = d;
      else   mdl_rdata = mdl_mem[a[7:2]];
    end
    e.rdata = mdl_rdata;
    sb.push_back(e);
  endtask

  // Called in an IDLE cycle (#1 after an edge); returns after the edge that leaves RESP.
  task automatic do_txn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output int bcyc, output logic [31:0] rd,
                        output logic e, output logic rdy_after);
    we    = w;
    adr   = a;
    wdata = d;
    if (sel == 0) req0 = 1'b1;
    else if (sel == 5) req5 = 1'b1;
    else req2 = 1'b1;
    if (sel == 2) predict(w, a, d);
    @(posedge clk); #1;
    req0 = 1'b0;
    req2 = 1'b0;
    req5 = 1'b0;
    cyc  = 1;
    bcyc = obs_busy(sel) ? 1 : 0;
    while (!obs_ready(sel) && cyc <= 40) begin
      @(posedge clk); #1;
      cyc++;
      if (obs_busy(sel)) bcyc++;
    end
    rd = obs_rdata(sel);
    e  = obs_err(sel);
    @(posedge clk); #1;
    rdy_after = obs_ready(sel);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b0; req2 = 1'b0; req5 = 1'b0;
    we = 1'b0; adr = '0; wdata = '0;
    mdl_rdata = '0;
    #3;
    checks++; if (ready2 !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready2); else passed++;
    checks++; if (err2 !== 1'b0) $display("FAIL reset_err: got %b want 0", err2); else passed++;
    checks++; if (busy2 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy2); else passed++;
    checks++; if (rdata2 !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata2); else passed++;
    checks++; if (busy5 !== 1'b0) $display("FAIL reset_busy5: got %b want 0", busy5); else passed++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_write_read();
    int cyc, bcyc; logic [31:0] rd; logic e, ra; exp_t ex;
    logic [31:0] pre_a [4];
    logic [31:0] pre_d [4];
    pre_a[0] = 32'h00; pre_d[0] = 32'h0BADF00D;
    pre_a[1] = 32'h04; pre_d[1] = 32'h01020304;
    pre_a[2] = 32'h08; pre_d[2] = 32'hAAAA5555;
    pre_a[3] = 32'h20; pre_d[3] = 32'h00000000;
    do_txn(2, 1'b1, 32'h10, 32'hDEADBEEF, cyc, bcyc, rd, e, ra);
    ex = sb.pop_front();
    checks++; if (cyc !== 3) $display("FAIL wr_latency: got %0d want 3", cyc); else passed++;
    checks++; if (e !== ex.err) $display("FAIL wr_err: got %b want %b", e, ex.err); else passed++;
    checks++;
    if (rd !== ex.rdata) $display("FAIL wr_rdata_held: got %h want %h", rd, ex.rdata);
    else passed++;
    checks++; if (ra !== 1'b0) $display("FAIL wr_ready_pulse: got %b want 0", ra); else passed++;
    // Issued in the IDLE cycle right after the write's RESP.
    do_txn(2, 1'b0, 32'h10, 32'h0, cyc, bcyc, rd, e, ra);
    ex = sb.pop_front();
    checks++; if (rd !== ex.rdata) $display("FAIL rd_data: got %h want %h", rd, ex.rdata); else passed++;
    checks++; if (e !== ex.err) $display("FAIL rd_err: got %b want %b", e, ex.err); else passed++;
    checks++; if (cyc !== 3) $display("FAIL rd_latency: got %0d want 3", cyc); else passed++;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (rdata2 !== 32'hDEADBEEF) $display("FAIL rd_hold: got %h want deadbeef", rdata2);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      do_txn(2, 1'b1, pre_a[i], pre_d[i], cyc, bcyc, rd, e, ra);
      ex = sb.pop_front();
      checks++; if (e !== ex.err) $display("FAIL pre_wr_err%0d: got %b want %b", i, e, ex.err);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    int cyc, bcyc; logic [31:0] rd; logic e, ra; exp_t ex;
    logic [31:0] a_tab [5];
    logic        w_tab [5];
    a_tab[0] = 32'h12;  w_tab[0] = 1'b1;
    a_tab[1] = 32'h10;  w_tab[1] = 1'b0;
    a_tab[2] = 32'h100; w_tab[2] = 1'b0;
    a_tab[3] = 32'hFC;  w_tab[3] = 1'b1;
    a_tab[4] = 32'hFC;  w_tab[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_txn(2, w_tab[i], a_tab[i], 32'hCAFEF00D ^ 32'(i), cyc, bcyc, rd, e, ra);
      ex = sb.pop_front();
      checks++; if (e !== ex.err) $display("FAIL illegal_err%0d: got %b want %b", i, e, ex.err);
      else passed++;
      checks++;
      if (rd !== ex.rdata) $display("FAIL illegal_rdata%0d: got %h want %h", i, rd, ex.rdata);
      else passed++;
    end
  endtask

  task automatic test_churn();
    int cyc, bcyc, pulses; logic [31:0] rd; logic e, ra; exp_t ex;
    we = 1'b0; adr = 32'h04; wdata = '0; req2 = 1'b1;
    predict(1'b0, 32'h04, 32'h0);
    @(posedge clk); #1;
    req2 = 1'b0; we = 1'b1; adr = 32'h08; wdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    req2 = 1'b1;
    checks++; if (ready2 !== 1'b0) $display("FAIL churn_early: got %b want 0", ready2); else passed++;
    @(posedge clk); #1;
    ex = sb.pop_front();
    checks++; if (ready2 !== 1'b1) $display("FAIL churn_ready: got %b want 1", ready2); else passed++;
    checks++;
    if (rdata2 !== ex.rdata) $display("FAIL churn_rdata: got %h want %h", rdata2, ex.rdata);
    else passed++;
    req2 = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready2) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL churn_extra: got %0d want 0", pulses); else passed++;
    do_txn(2, 1'b0, 32'h08, 32'h0, cyc, bcyc, rd, e, ra);
    ex = sb.pop_front();
    checks++; if (rd !== ex.rdata) $display("FAIL churn_nowrite: got %h want %h", rd, ex.rdata);
    else passed++;
  endtask

  task automatic test_reset_mid_write();
    int cyc, bcyc; logic [31:0] rd; logic e, ra; exp_t ex;
    do_txn(2, 1'b0, 32'h04, 32'h0, cyc, bcyc, rd, e, ra);
    ex = sb.pop_front();
    checks++; if (rd !== ex.rdata) $display("FAIL rst_pre_rd: got %h want %h", rd, ex.rdata);
    else passed++;
    we = 1'b1; adr = 32'h20; wdata = 32'h12345678; req2 = 1'b1;
    @(posedge clk); #1;
    req2 = 1'b0;
    checks++; if (busy2 !== 1'b1) $display("FAIL rst_wait_busy: got %b want 1", busy2); else passed++;
    reset = 1'b1;
    #1;
    mdl_rdata = '0;
    checks++; if (ready2 !== 1'b0) $display("FAIL rst_async_ready: got %b want 0", ready2);
    else passed++;
    checks++; if (busy2 !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", busy2);
    else passed++;
    checks++; if (err2 !== 1'b0) $display("FAIL rst_async_err: got %b want 0", err2); else passed++;
    checks++; if (rdata2 !== 32'h0) $display("FAIL rst_async_rdata: got %h want 0", rdata2);
    else passed++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    do_txn(2, 1'b0, 32'h20, 32'h0, cyc, bcyc, rd, e, ra);
    ex = sb.pop_front();
    checks++; if (rd !== ex.rdata) $display("FAIL rst_aborted_wr: got %h want %h", rd, ex.rdata);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc; exp_t ex;
    reset = 1'b1;
    we = 1'b0; adr = 32'h00; req2 = 1'b1;
    mdl_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    predict(1'b0, 32'h00, 32'h0);
    @(posedge clk); #1;
    req2 = 1'b0;
    cyc = 1;
    while (!ready2 && cyc <= 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    ex = sb.pop_front();
    checks++; if (cyc !== 3) $display("FAIL b2b_latency: got %0d want 3", cyc); else passed++;
    checks++; if (rdata2 !== ex.rdata) $display("FAIL b2b_rdata: got %h want %h", rdata2, ex.rdata);
    else passed++;
    checks++; if (err2 !== ex.err) $display("FAIL b2b_err: got %b want %b", err2, ex.err); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int cyc, bcyc, pulses, first; logic [31:0] rd; logic e, ra;
    do_txn(0, 1'b1, 32'h12, 32'h1, cyc, bcyc, rd, e, ra);
    checks++; if (cyc !== 1) $display("FAIL lat0_latency: got %0d want 1", cyc); else passed++;
    checks++; if (e !== 1'b1) $display("FAIL lat0_err: got %b want 1", e); else passed++;
    checks++; if (bcyc !== 1) $display("FAIL lat0_busy: got %0d want 1", bcyc); else passed++;
    we = 1'b0; adr = 32'h00; req0 = 1'b1;
    pulses = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready0) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    req0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (pulses !== 5) $display("FAIL lat0_rate: got %0d want 5", pulses); else passed++;
    checks++; if (first !== 0) $display("FAIL lat0_first: got %0d want 0", first); else passed++;
    do_txn(5, 1'b0, 32'h00, 32'h0, cyc, bcyc, rd, e, ra);
    checks++; if (cyc !== 6) $display("FAIL lat5_latency: got %0d want 6", cyc); else passed++;
    checks++; if (bcyc !== 6) $display("FAIL lat5_busy: got %0d want 6", bcyc); else passed++;
    checks++; if (ra !== 1'b0) $display("FAIL lat5_pulse: got %b want 0", ra); else passed++;
    do_txn(5, 1'b0, 32'h100, 32'h0, cyc, bcyc, rd, e, ra);
    checks++; if (e !== 1'b1) $display("FAIL lat5_err: got %b want 1", e); else passed++;
    checks++; if (rd !== 32'h0) $display("FAIL lat5_rdata: got %h want 0", rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_illegal();
    test_churn();
    test_reset_mid_write();
    test_back_to_back();
    test_latency();
    checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", checks, passed);
    $fatal(1);
  end

endmodule
